// File: rtl/sik_pkg.sv
// Definitions shared by the SIK core and its memory responder.
package sik_pkg;
   localparam int WORD_W = 16;
   localparam int ADDR_W = 16;

   typedef logic [WORD_W-1:0] word_t;
   typedef logic [ADDR_W-1:0] addr_t;
   typedef logic              tid_t;   // 0 = thread 1, 1 = thread 2

   // Opcode field (instruction bits [15:12]) as seen by the core decoder.
   localparam logic [3:0] OP_LOAD  = 4'h8;
   localparam logic [3:0] OP_STORE = 4'h9;
   localparam logic [3:0] OP_EXT   = 4'hF;
   localparam word_t      NOOP     = 16'h0000;

   typedef enum logic [1:0] {GNT_NONE, GNT_FETCH, GNT_DATA} grant_e;
endpackage

// File: rtl/sik_mem_responder_if.sv
// Core <-> memory responder channels: fetch request, data request, fetch and load responses.
interface sik_mem_responder_if #(parameter int DW = sik_pkg::WORD_W);
   import sik_pkg::*;

   logic          if_req_valid;
   logic          if_req_ready;
   addr_t         if_req_addr;
   tid_t          if_req_tid;

   logic          d_req_valid;
   logic          d_req_ready;
   logic          d_req_we;
   addr_t         d_req_addr;
   logic [DW-1:0] d_req_wdata;
   tid_t          d_req_tid;

   logic          if_resp_valid;
   logic [DW-1:0] if_resp_data;
   tid_t          if_resp_tid;

   logic          d_resp_valid;
   logic          d_resp_ready;
   logic [DW-1:0] d_resp_data;
   tid_t          d_resp_tid;

   modport slave (
      input  if_req_valid, if_req_addr, if_req_tid,
      input  d_req_valid, d_req_we, d_req_addr, d_req_wdata, d_req_tid, d_resp_ready,
      output if_req_ready, d_req_ready,
      output if_resp_valid, if_resp_data, if_resp_tid,
      output d_resp_valid, d_resp_data, d_resp_tid
   );

   modport master (
      output if_req_valid, if_req_addr, if_req_tid,
      output d_req_valid, d_req_we, d_req_addr, d_req_wdata, d_req_tid, d_resp_ready,
      input  if_req_ready, d_req_ready,
      input  if_resp_valid, if_resp_data, if_resp_tid,
      input  d_resp_valid, d_resp_data, d_resp_tid
   );
endinterface

// File: rtl/sik_resp_fifo2.sv
// Two-entry valid/ready FIFO; occupancy is exported so the owner can budget load credits.
module sik_resp_fifo2 #(
   parameter int W = 17
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push_valid_i,
   output logic         push_ready_o,
   input  logic [W-1:0] push_data_i,
   output logic         pop_valid_o,
   input  logic         pop_ready_i,
   output logic [W-1:0] pop_data_o,
   output logic [1:0]   count_o
);
   logic [W-1:0] ent_q [2];
   logic         wr_q, rd_q;
   logic [1:0]   cnt_q, cnt_d;
   logic         push, pop;

   assign push_ready_o = (cnt_q != 2'd2);
   assign pop_valid_o  = (cnt_q != 2'd0);
   assign pop_data_o   = ent_q[rd_q];
   assign count_o      = cnt_q;
   assign push         = push_valid_i && push_ready_o;
   assign pop          = pop_valid_o && pop_ready_i;
   assign cnt_d        = cnt_q + {1'b0, push} - {1'b0, pop};

   always_ff @(posedge clk) begin
      if (push) ent_q[wr_q] <= push_data_i;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_q  <= 1'b0;
         rd_q  <= 1'b0;
         cnt_q <= 2'd0;
      end else begin
         if (push) wr_q <= ~wr_q;
         if (pop)  rd_q <= ~rd_q;
         cnt_q <= cnt_d;
      end
   end
endmodule

// File: rtl/sik_mem_responder.sv
// Memory-side responder: one array port shared by fetch and data, reads answered two edges
// after acceptance, loads returned in order through a credit-limited 2-entry FIFO.
module sik_mem_responder
   import sik_pkg::*;
#(
   parameter int AW           = 16,
   parameter int DW           = WORD_W,
   parameter int STARVE_LIMIT = 3
) (
   input  logic clk,
   input  logic reset,              // asynchronous, active low
   sik_mem_responder_if.slave bus
);
   localparam int            DEPTH      = 1 << AW;
   localparam int            SW         = $clog2(STARVE_LIMIT + 1);
   localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

   logic [DW-1:0] mem_q [DEPTH];
   grant_e        grant;
   logic [SW-1:0] starve_q, starve_d;
   logic          s1_vld_q, s1_vld_d, s1_fetch_q, s1_fetch_d;
   tid_t          s1_tid_q, s1_tid_d;
   logic [DW-1:0] s1_data_q;
   logic          if_vld_q;
   tid_t          if_tid_q;
   logic [DW-1:0] if_data_q;
   logic [AW-1:0] acc_addr;
   logic [1:0]    credits, fifo_cnt;
   logic          fifo_in_rdy, s1_ld, data_ok, force_fetch;
   logic [DW:0]   fifo_out;

   // Every outstanding load owns a FIFO slot, whether still in stage 1 or already queued.
   assign s1_ld       = s1_vld_q && !s1_fetch_q;
   assign credits     = 2'd2 - {1'b0, s1_ld} - fifo_cnt;
   assign data_ok     = (credits != 2'd0) && fifo_in_rdy;
   assign force_fetch = (starve_q == STARVE_MAX);

   assign bus.d_req_ready  = reset && data_ok && !(force_fetch && bus.if_req_valid);
   assign bus.if_req_ready = reset && (force_fetch || !(bus.d_req_valid && data_ok));

   always_comb begin
      grant = GNT_NONE;
      if (bus.d_req_valid && bus.d_req_ready)        grant = GNT_DATA;
      else if (bus.if_req_valid && bus.if_req_ready) grant = GNT_FETCH;
   end

   always_comb begin
      acc_addr   = (grant == GNT_FETCH) ? bus.if_req_addr[AW-1:0] : bus.d_req_addr[AW-1:0];
      s1_vld_d   = (grant == GNT_FETCH) || (grant == GNT_DATA && !bus.d_req_we);
      s1_fetch_d = (grant == GNT_FETCH);
      s1_tid_d   = (grant == GNT_FETCH) ? bus.if_req_tid : bus.d_req_tid;
      starve_d   = starve_q;
      if (!bus.if_req_valid || grant == GNT_FETCH)
         starve_d = '0;
      else if (grant == GNT_DATA && !force_fetch)
         starve_d = starve_q + SW'(1);
   end

   always_ff @(posedge clk) begin
      if (grant == GNT_DATA && bus.d_req_we)
         mem_q[bus.d_req_addr[AW-1:0]] <= bus.d_req_wdata;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         starve_q   <= '0;
         s1_vld_q   <= 1'b0;
         s1_fetch_q <= 1'b0;
         s1_tid_q   <= 1'b0;
         s1_data_q  <= '0;
         if_vld_q   <= 1'b0;
         if_tid_q   <= 1'b0;
         if_data_q  <= '0;
      end else begin
         starve_q   <= starve_d;
         s1_vld_q   <= s1_vld_d;
         s1_fetch_q <= s1_fetch_d;
         s1_tid_q   <= s1_tid_d;
         s1_data_q  <= mem_q[acc_addr];
         if_vld_q   <= s1_vld_q && s1_fetch_q;
         if_tid_q   <= s1_tid_q;
         if_data_q  <= s1_data_q;
      end
   end

   sik_resp_fifo2 #(.W(DW + 1)) u_resp_fifo (
      .clk          (clk),
      .rst_n        (reset),
      .push_valid_i (s1_ld),
      .push_ready_o (fifo_in_rdy),
      .push_data_i  ({s1_tid_q, s1_data_q}),
      .pop_valid_o  (bus.d_resp_valid),
      .pop_ready_i  (bus.d_resp_ready),
      .pop_data_o   (fifo_out),
      .count_o      (fifo_cnt)
   );

   assign bus.d_resp_tid    = fifo_out[DW];
   assign bus.d_resp_data   = fifo_out[DW-1:0];
   assign bus.if_resp_valid = if_vld_q;
   assign bus.if_resp_data  = if_data_q;
   assign bus.if_resp_tid   = if_tid_q;
endmodule

// File: tb/tb_sik_mem_responder.sv
// Bench for sik_mem_responder (AW=8): directed scenarios with literal expectations plus a
// randomized run, all outputs compared every cycle against a queue-based reference model.
module tb_sik_mem_responder;
   localparam int LIMIT = 3;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   sik_mem_responder_if #(.DW(16)) bus ();

   sik_mem_responder #(.AW(8), .DW(16), .STARVE_LIMIT(LIMIT)) dut (
      .clk   (clk),
      .reset (rst_n),
      .bus   (bus)
   );

   int n_pass = 0;
   int n_total = 0;
   int cyc_n = 0;

   typedef struct {
      int          due;
      logic [15:0] data;
      logic        tid;
   } rsp_t;

   rsp_t        fq[$];
   rsp_t        lq[$];
   int          starve_m = 0;
   logic [15:0] mem_m [256];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc_n, act, exp);
   endtask

   // Reference model: outstanding loads in a queue (credits = 2 - size), fetches tagged with
   // the cycle their response is due, memory as a plain array.
   task automatic model_step();
      int cred;
      bit frc, exp_ifr, exp_dr, exp_ifv, exp_dv, facc, dacc;
      cyc_n++;
      while (fq.size() > 0 && fq[0].due < cyc_n) fq.delete(0);
      if (!rst_n) begin
         fq.delete();
         lq.delete();
         starve_m = 0;
         chk("rst_if_ready", 32'(bus.if_req_ready), 0);
         chk("rst_d_ready", 32'(bus.d_req_ready), 0);
         chk("rst_if_resp_valid", 32'(bus.if_resp_valid), 0);
         chk("rst_d_resp_valid", 32'(bus.d_resp_valid), 0);
         return;
      end
      cred    = 2 - lq.size();
      frc     = (starve_m == LIMIT);
      exp_dr  = (cred > 0) && !(frc && bus.if_req_valid);
      exp_ifr = frc || !(bus.d_req_valid && cred > 0);
      exp_ifv = (fq.size() > 0) && (fq[0].due == cyc_n);
      exp_dv  = (lq.size() > 0) && (lq[0].due <= cyc_n);
      chk("if_req_ready", 32'(bus.if_req_ready), 32'(exp_ifr));
      chk("d_req_ready", 32'(bus.d_req_ready), 32'(exp_dr));
      chk("if_resp_valid", 32'(bus.if_resp_valid), 32'(exp_ifv));
      chk("d_resp_valid", 32'(bus.d_resp_valid), 32'(exp_dv));
      if (exp_ifv) begin
         chk("if_resp_data", 32'(bus.if_resp_data), 32'(fq[0].data));
         chk("if_resp_tid", 32'(bus.if_resp_tid), 32'(fq[0].tid));
      end
      if (exp_dv) begin
         chk("d_resp_data", 32'(bus.d_resp_data), 32'(lq[0].data));
         chk("d_resp_tid", 32'(bus.d_resp_tid), 32'(lq[0].tid));
         if (bus.d_resp_ready) lq.delete(0);
      end
      facc = bus.if_req_valid && exp_ifr;
      dacc = bus.d_req_valid && exp_dr;
      if (facc) fq.push_back('{cyc_n + 2, mem_m[bus.if_req_addr[7:0]], bus.if_req_tid});
      if (dacc) begin
         if (bus.d_req_we) mem_m[bus.d_req_addr[7:0]] = bus.d_req_wdata;
         else lq.push_back('{cyc_n + 2, mem_m[bus.d_req_addr[7:0]], bus.d_req_tid});
      end
      if (!bus.if_req_valid || facc) starve_m = 0;
      else if (dacc && starve_m < LIMIT) starve_m++;
   endtask

   initial begin
      forever begin
         @(negedge clk);
         #4;
         model_step();
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog cyc=%0d", cyc_n);
      $fatal(1, "timeout");
   end

   task automatic cyc();
      @(negedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic set_d(input logic v, input logic we, input logic [15:0] a,
                        input logic [15:0] wd, input logic t);
      bus.d_req_valid = v;
      bus.d_req_we    = we;
      bus.d_req_addr  = a;
      bus.d_req_wdata = wd;
      bus.d_req_tid   = t;
   endtask

   task automatic set_if(input logic v, input logic [15:0] a, input logic t);
      bus.if_req_valid = v;
      bus.if_req_addr  = a;
      bus.if_req_tid   = t;
   endtask

   initial begin
      logic [15:0] pv;
      rst_n = 1'b1;
      set_if(0, 16'h0, 0);
      set_d(0, 0, 16'h0, 16'h0, 0);
      bus.d_resp_ready = 1'b1;
      #2 rst_n = 1'b0;
      cyc();
      cyc();
      settle();
      chk("t0_if_ready", 32'(bus.if_req_ready), 0);
      chk("t0_d_ready", 32'(bus.d_req_ready), 0);
      chk("t0_if_valid", 32'(bus.if_resp_valid), 0);
      chk("t0_d_valid", 32'(bus.d_resp_valid), 0);
      cyc();
      rst_n = 1'b1;

      // Preload through the store path; a few words get known values.
      for (int a = 0; a < 256; a++) begin
         case (a)
            4:       pv = 16'h1234;
            20:      pv = 16'hA020;
            21:      pv = 16'hA021;
            22:      pv = 16'hA022;
            255:     pv = 16'hF0FF;
            default: pv = 16'($urandom);
         endcase
         set_d(1, 1, 16'(a), pv, 0);
         cyc();
      end
      set_d(0, 0, 16'h0, 16'h0, 0);

      // Fetch latency 2, single-cycle response.
      set_if(1, 16'd4, 1);
      settle();
      chk("t1_if_ready", 32'(bus.if_req_ready), 1);
      cyc();
      set_if(0, 16'd0, 0);
      settle();
      chk("t1_early", 32'(bus.if_resp_valid), 0);
      cyc();
      settle();
      chk("t1_valid", 32'(bus.if_resp_valid), 1);
      chk("t1_data", 32'(bus.if_resp_data), 32'h1234);
      chk("t1_tid", 32'(bus.if_resp_tid), 1);
      cyc();
      settle();
      chk("t1_drop", 32'(bus.if_resp_valid), 0);

      // Store then load of the same word.
      set_d(1, 1, 16'd9, 16'hBEEF, 0);
      cyc();
      set_d(1, 0, 16'd9, 16'h0, 0);
      settle();
      chk("t2_ld_ready", 32'(bus.d_req_ready), 1);
      cyc();
      set_d(0, 0, 16'h0, 16'h0, 0);
      settle();
      chk("t2_no_store_resp", 32'(bus.d_resp_valid), 0);
      cyc();
      settle();
      chk("t2_valid", 32'(bus.d_resp_valid), 1);
      chk("t2_data", 32'(bus.d_resp_data), 32'hBEEF);
      cyc();

      // Credit exhaustion with response backpressure.
      bus.d_resp_ready = 1'b0;
      set_d(1, 0, 16'd20, 16'h0, 0);
      settle();
      chk("t3_rdy0", 32'(bus.d_req_ready), 1);
      cyc();
      set_d(1, 0, 16'd21, 16'h0, 1);
      settle();
      chk("t3_rdy1", 32'(bus.d_req_ready), 1);
      cyc();
      set_d(1, 0, 16'd22, 16'h0, 0);
      settle();
      chk("t3_rdy2", 32'(bus.d_req_ready), 0);
      cyc();
      settle();
      chk("t3_rdy3", 32'(bus.d_req_ready), 0);
      chk("t3_v0", 32'(bus.d_resp_valid), 1);
      chk("t3_d0", 32'(bus.d_resp_data), 32'hA020);
      bus.d_resp_ready = 1'b1;
      settle();
      chk("t3_rdy_pop", 32'(bus.d_req_ready), 0);
      cyc();
      settle();
      chk("t3_d1", 32'(bus.d_resp_data), 32'hA021);
      chk("t3_tid1", 32'(bus.d_resp_tid), 1);
      chk("t3_rdy_back", 32'(bus.d_req_ready), 1);
      cyc();
      set_d(0, 0, 16'h0, 16'h0, 0);
      settle();
      chk("t3_gap", 32'(bus.d_resp_valid), 0);
      cyc();
      settle();
      chk("t3_v2", 32'(bus.d_resp_valid), 1);
      chk("t3_d2", 32'(bus.d_resp_data), 32'hA022);
      cyc();

      // Continuous contention: D,D,D,F repeating.
      set_d(1, 1, 16'd30, 16'h3030, 0);
      set_if(1, 16'd31, 0);
      for (int i = 0; i < 8; i++) begin
         settle();
         chk($sformatf("t4_d_ready_%0d", i), 32'(bus.d_req_ready), 32'((i % 4) != 3));
         chk($sformatf("t4_if_ready_%0d", i), 32'(bus.if_req_ready), 32'((i % 4) == 3));
         cyc();
      end
      set_d(0, 0, 16'h0, 16'h0, 0);
      set_if(0, 16'h0, 0);
      cyc();
      cyc();
      cyc();

      // Reset with two loads in flight.
      bus.d_resp_ready = 1'b0;
      set_d(1, 0, 16'd40, 16'h0, 0);
      cyc();
      set_d(1, 0, 16'd41, 16'h0, 0);
      cyc();
      set_d(0, 0, 16'h0, 16'h0, 0);
      settle();
      chk("t5_inflight", 32'(bus.d_resp_valid), 1);
      rst_n = 1'b0;
      settle();
      chk("t5_d_valid", 32'(bus.d_resp_valid), 0);
      chk("t5_if_valid", 32'(bus.if_resp_valid), 0);
      chk("t5_d_ready", 32'(bus.d_req_ready), 0);
      chk("t5_if_ready", 32'(bus.if_req_ready), 0);
      cyc();
      rst_n = 1'b1;
      bus.d_resp_ready = 1'b1;
      settle();
      chk("t5_rdy_after", 32'(bus.d_req_ready), 1);
      for (int i = 0; i < 3; i++) begin
         cyc();
         settle();
         chk($sformatf("t5_stale_%0d", i), 32'(bus.d_resp_valid), 0);
      end
      bus.d_resp_ready = 1'b0;
      set_d(1, 0, 16'd4, 16'h0, 0);
      settle();
      chk("t5_cred2", 32'(bus.d_req_ready), 1);
      cyc();
      settle();
      chk("t5_cred1", 32'(bus.d_req_ready), 1);
      cyc();
      set_d(0, 0, 16'h0, 16'h0, 0);
      settle();
      chk("t5_cred0", 32'(bus.d_req_ready), 0);
      bus.d_resp_ready = 1'b1;
      cyc();
      cyc();
      cyc();

      // Address wrap modulo 256.
      set_d(1, 0, 16'hFFFF, 16'h0, 1);
      cyc();
      set_d(0, 0, 16'h0, 16'h0, 0);
      cyc();
      settle();
      chk("t6_valid", 32'(bus.d_resp_valid), 1);
      chk("t6_data", 32'(bus.d_resp_data), 32'hF0FF);
      chk("t6_tid", 32'(bus.d_resp_tid), 1);
      cyc();
      set_if(1, 16'h0104, 0);
      cyc();
      set_if(0, 16'h0, 0);
      cyc();
      settle();
      chk("t6_fetch_wrap", 32'(bus.if_resp_data), 32'h1234);
      cyc();

      // Randomized traffic with occasional resets.
      for (int i = 0; i < 3000; i++) begin
         rst_n = ($urandom_range(0, 299) != 0);
         set_if($urandom_range(0, 3) != 0, 16'($urandom), 1'($urandom));
         set_d($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, 16'($urandom),
               16'($urandom), 1'($urandom));
         bus.d_resp_ready = ($urandom_range(0, 3) != 0);
         cyc();
      end
      rst_n = 1'b1;
      set_if(0, 16'h0, 0);
      set_d(0, 0, 16'h0, 16'h0, 0);
      bus.d_resp_ready = 1'b1;
      for (int i = 0; i < 6; i++) cyc();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

// File: doc/sik_mem_responder.md
Name: sik_mem_responder

Overview:
- Memory-side responder for the two-thread SIK pipeline; answers instruction-fetch and data load/store requests from the core.
- Owns the unified 16-bit-word memory array.
- Arbitrates the fetch and data channels onto a single access port per cycle.
- Returns read data with fixed latency, tagged by thread id.

Parameters:
- AW, 16, address bits used; DEPTH = 2**AW words; upper request address bits ignored (wrap modulo DEPTH).
- DW, 16, data word width.
- STARVE_LIMIT, 3, max consecutive data grants while a fetch is pending before fetch is forced.

Ports:
- clk  in  1  system clock, posedge.
- reset  in  1  asynchronous, active-low reset.
- if_req_valid  in  1  fetch request present.
- if_req_ready  out  1  fetch request accepted this cycle.
- if_req_addr  in  16  fetch word address (pc).
- if_req_tid  in  1  thread id, 0 = thread 1, 1 = thread 2.
- d_req_valid  in  1  data request present.
- d_req_ready  out  1  data request accepted this cycle.
- d_req_we  in  1  1 = store, 0 = load.
- d_req_addr  in  16  data word address.
- d_req_wdata  in  DW  store data.
- d_req_tid  in  1  thread id.
- if_resp_valid  out  1  fetch data valid, single cycle, no backpressure.
- if_resp_data  out  DW  fetched instruction word.
- if_resp_tid  out  1  tid echoed.
- d_resp_valid  out  1  load data valid.
- d_resp_ready  in  1  core accepts load data.
- d_resp_data  out  DW  load result.
- d_resp_tid  out  1  tid echoed.

Behaviour:
- Reset (reset low, asynchronous):
  - All valids 0; both ready outputs 0 while reset is low; starve counter 0; load credits 2; response FIFO empty.
  - Memory contents are not cleared; the bench loads them.
- Handshake: a transfer occurs on a posedge where valid && ready. Ready is a combinational function of registered state plus the other channel's valid. Ready never depends on its own channel's valid.
- Arbitration, one grant per cycle:
  - Data has priority if d_req_valid && credits>0.
  - Fetch wins instead if the starve counter equals STARVE_LIMIT and if_req_valid.
  - Otherwise fetch wins if if_req_valid.
- Starve counter:
  - Increments on each data grant made while if_req_valid=1.
  - Clears on any fetch grant, or on any cycle where if_req_valid=0.
  - Saturates at STARVE_LIMIT.
- Stores:
  - Memory is written at the accepting edge. No response is generated and no credit is consumed.
  - A load or fetch accepted on any later edge sees the new value.
- Loads and fetches:
  - The array is read at the accepting edge N into a stage-1 register, then into the output register at N+1.
  - if_resp_valid and d_resp_valid rise after edge N+1 (latency 2 from acceptance).
- Fetch response:
  - Held for exactly one cycle.
  - Fetch back-to-back acceptance is allowed; throughput is 1/cycle.
- Data response and credits:
  - Load responses enter a 2-entry FIFO and are presented in order.
  - A credit is consumed on load acceptance and returned when d_resp_valid && d_resp_ready.
  - With credits = 0, d_req_ready = 0 and fetch may take the port.
  - A credit returned and a credit consumed on the same edge leave the count unchanged.
  - Responses are never dropped or reordered.
- Address wrap: addr[AW-1:0] indexes the array; no error on overflow.
- Reset mid-operation: in-flight reads and FIFO contents are discarded; no response appears after reset deasserts until a new acceptance.
- Simultaneous fetch and data valids to the same address: the grant follows arbitration; the losing request stays pending, with no combining.

Decomposition:
- Shared package sik_pkg holds:
  - WORD/DW width, the address width, and the tid type.
  - The opcode constants (normal and extended OP codes, the NOOP sentinel) already used by the core decoder.
- One natural sub-module: sik_resp_fifo2, a 2-entry valid/ready FIFO with count output, instantiated for the data response path.

Test Plan:
1. Memory preloaded mem[4]=16'h1234; fetch addr 4 tid 1 accepted at edge 0 -> if_resp_valid high in exactly cycle after edge 1, data 16'h1234, tid 1, then low.
2. Store addr 9 wdata 16'hBEEF at edge 0, load addr 9 at edge 1 -> d_resp_data 16'hBEEF after edge 2; no response for the store.
3. d_resp_ready=0, issue 3 loads back-to-back -> first two accepted, d_req_ready=0 on the third. Raise ready -> 2 responses in order, then the third is accepted.
4. Fetch and data valid continuously, STARVE_LIMIT=3 -> grant pattern D,D,D,F repeating; the fetch latency bound holds.
5. Two loads in flight, pull reset low for one cycle -> all valids 0 immediately, credits=2 after release, no stale responses.
6. Load address 16'hFFFF with AW=8 -> returns mem[8'hFF].
